// File: rtl/fetch_controller.sv
// fetch_controller: instruction-fetch sequencer between program_counter,
// instruction memory and decode. Issues one memory read per instruction,
// holds the fetched word until decode accepts it, handles branch redirects
// and stops fetching when the PC overflows.
module fetch_controller (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:0]  pc,
   input  logic        pc_overflow,
   output logic        fetch,
   output logic        pc_write,
   output logic [9:0]  pc_addr,
   output logic        imem_req,
   output logic [9:0]  imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   input  logic        branch_valid,
   input  logic [9:0]  branch_target,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        halted
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      HOLD,
      REDIRECT,
      HALT
   } state_e;

   state_e      state_q, state_d;
   logic        fetch_q, fetch_d;
   logic        pc_write_q, pc_write_d;
   logic [9:0]  pc_addr_q, pc_addr_d;
   logic        imem_req_q, imem_req_d;
   logic [31:0] instr_q, instr_d;
   logic        instr_valid_q, instr_valid_d;
   logic        halted_q, halted_d;

   // State and registered outputs; synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         fetch_q       <= 1'b0;
         pc_write_q    <= 1'b0;
         pc_addr_q     <= '0;
         imem_req_q    <= 1'b0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_q       <= fetch_d;
         pc_write_q    <= pc_write_d;
         pc_addr_q     <= pc_addr_d;
         imem_req_q    <= imem_req_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         halted_q      <= halted_d;
      end
   end

   // Next-state: branch beats overflow beats memory ack
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     state_d = FETCH;
         FETCH: begin
            if (branch_valid)     state_d = REDIRECT;
            else if (pc_overflow) state_d = HALT;
            else if (imem_ack)    state_d = HOLD;
         end
         HOLD: begin
            if (branch_valid)     state_d = REDIRECT;
            else if (instr_ready) state_d = FETCH;
         end
         REDIRECT: state_d = FETCH;
         HALT: begin
            if (branch_valid)     state_d = REDIRECT;
         end
         default:  state_d = IDLE;
      endcase
   end

   // Output next values; the request is registered from the next state so
   // it is high for exactly the cycles spent in FETCH
   always_comb begin
      fetch_d       = 1'b0;
      pc_write_d    = 1'b0;
      pc_addr_d     = pc_addr_q;
      imem_req_d    = (state_d == FETCH);
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      halted_d      = halted_q;
      unique case (state_q)
         FETCH: begin
            if (branch_valid) begin
               pc_write_d    = 1'b1;
               pc_addr_d     = branch_target;
               instr_valid_d = 1'b0;
               halted_d      = 1'b0;
            end else if (pc_overflow) begin
               halted_d      = 1'b1;
               instr_valid_d = 1'b0;
            end else if (imem_ack) begin
               instr_d       = imem_data;
               instr_valid_d = 1'b1;
               fetch_d       = 1'b1;
            end
         end
         HOLD: begin
            if (branch_valid) begin
               pc_write_d    = 1'b1;
               pc_addr_d     = branch_target;
               instr_valid_d = 1'b0;
               halted_d      = 1'b0;
            end else if (instr_ready) begin
               instr_valid_d = 1'b0;
            end
         end
         HALT: begin
            if (branch_valid) begin
               pc_write_d    = 1'b1;
               pc_addr_d     = branch_target;
               instr_valid_d = 1'b0;
               halted_d      = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign fetch       = fetch_q;
   assign pc_write    = pc_write_q;
   assign pc_addr     = pc_addr_q;
   assign imem_req    = imem_req_q;
   assign imem_addr   = pc;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed testbench for fetch_controller: hand-computed expectations for
// reset, normal fetch, decode stall, branch redirects, overflow halt and
// mid-request reset.
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  pc;
   logic        pc_overflow;
   logic        fetch;
   logic        pc_write;
   logic [9:0]  pc_addr;
   logic        imem_req;
   logic [9:0]  imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic        branch_valid;
   logic [9:0]  branch_target;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        halted;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   fetch_controller dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pc            (pc),
      .pc_overflow   (pc_overflow),
      .fetch         (fetch),
      .pc_write      (pc_write),
      .pc_addr       (pc_addr),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_data     (imem_data),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // advance one clock; outputs are sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // control-output snapshot {fetch, pc_write, imem_req, instr_valid, halted}
   function automatic logic [31:0] ctl();
      return {27'd0, fetch, pc_write, imem_req, instr_valid, halted};
   endfunction

   initial begin
      rst_n = 1'b0; pc = '0; pc_overflow = 1'b0; imem_ack = 1'b0;
      imem_data = '0; branch_valid = 1'b0; branch_target = '0; instr_ready = 1'b1;
      step(); step();
      check("rst_ctl",   ctl(), 32'b00000);
      check("rst_instr", instr, 32'h0);
      check("rst_paddr", {22'd0, pc_addr}, 32'd0);

      // normal fetch, ack on 2nd FETCH cycle
      rst_n = 1'b1;
      step();                                   // IDLE -> FETCH
      check("f1_ctl",  ctl(), 32'b00100);
      check("f1_addr", {22'd0, imem_addr}, 32'd0);
      step();                                   // still waiting
      check("f1_wait", ctl(), 32'b00100);
      imem_ack = 1'b1; imem_data = 32'hDEADBEEF;
      step();                                   // -> HOLD
      imem_ack = 1'b0;
      check("f1_hold_ctl", ctl(), 32'b10010);
      check("f1_instr",    instr, 32'hDEADBEEF);
      step();                                   // accepted -> FETCH
      pc = 10'd1;
      check("f1_next_ctl", ctl(), 32'b00100);
      check("f1_next_addr", {22'd0, imem_addr}, 32'd1);

      // decode stall for 5 cycles
      instr_ready = 1'b0;
      imem_ack = 1'b1; imem_data = 32'h12345678;
      step();
      imem_ack = 1'b0;
      check("st_first", ctl(), 32'b10010);
      pc = 10'd2;
      for (int i = 0; i < 5; i++) begin
         step();
         check("st_ctl",   ctl(), 32'b00010);
         check("st_instr", instr, 32'h12345678);
      end

      // branch in HOLD to 50; branch held high during REDIRECT is ignored
      branch_valid = 1'b1; branch_target = 10'd50;
      step();
      check("bh_ctl",   ctl(), 32'b01000);
      check("bh_paddr", {22'd0, pc_addr}, 32'd50);
      pc = 10'd50;
      step();
      branch_valid = 1'b0;
      check("bh_fetch_ctl",  ctl(), 32'b00100);
      check("bh_fetch_addr", {22'd0, imem_addr}, 32'd50);
      instr_ready = 1'b1;

      // branch coincident with ack: data discarded
      imem_ack = 1'b1; imem_data = 32'hCAFEF00D;
      branch_valid = 1'b1; branch_target = 10'd100;
      step();
      imem_ack = 1'b0; branch_valid = 1'b0;
      check("ba_ctl",   ctl(), 32'b01000);
      check("ba_paddr", {22'd0, pc_addr}, 32'd100);
      check("ba_instr", instr, 32'h12345678);
      pc = 10'd100;
      step();
      check("ba_fetch_ctl",  ctl(), 32'b00100);
      check("ba_fetch_addr", {22'd0, imem_addr}, 32'd100);

      // fetch at 1023, then overflow -> HALT, branch to 5 resumes
      pc = 10'd1023;
      imem_ack = 1'b1; imem_data = 32'h00000013;
      step();
      imem_ack = 1'b0;
      check("ov_hold", ctl(), 32'b10010);
      step();
      pc = 10'd0; pc_overflow = 1'b1;
      check("ov_fetch", ctl(), 32'b00100);
      step();
      check("ov_halt", ctl(), 32'b00001);
      step();
      check("ov_halt2", ctl(), 32'b00001);
      branch_valid = 1'b1; branch_target = 10'd5;
      step();
      branch_valid = 1'b0;
      check("ov_redir",  ctl(), 32'b01000);
      check("ov_paddr", {22'd0, pc_addr}, 32'd5);
      pc = 10'd5; pc_overflow = 1'b0;
      step();
      check("ov_resume",      ctl(), 32'b00100);
      check("ov_resume_addr", {22'd0, imem_addr}, 32'd5);
      imem_ack = 1'b1; imem_data = 32'hAAAA5555;
      step();
      imem_ack = 1'b0;
      check("ov_fetch5", ctl(), 32'b10010);
      check("ov_instr5", instr, 32'hAAAA5555);

      // branch in HOLD coincident with accept: transfer completes, redirect
      branch_valid = 1'b1; branch_target = 10'd7;
      step();
      branch_valid = 1'b0;
      check("bt_ctl",   ctl(), 32'b01000);
      check("bt_paddr", {22'd0, pc_addr}, 32'd7);
      pc = 10'd7;
      step();
      check("bt_fetch", ctl(), 32'b00100);

      // reset mid-FETCH with ack pending
      imem_ack = 1'b1; imem_data = 32'h55555555; rst_n = 1'b0;
      step();
      check("mr_ctl",   ctl(), 32'b00000);
      check("mr_instr", instr, 32'h0);
      check("mr_paddr", {22'd0, pc_addr}, 32'd0);
      rst_n = 1'b1; imem_ack = 1'b0;
      step();
      check("mr_fetch", ctl(), 32'b00100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-003 SHALL have port pc  input  10  current PC value from program_counter.
REQ-004 SHALL have port pc_overflow  input  1  program_counter wrap/overflow flag.
REQ-005 SHALL have port fetch  output  1  one-cycle pulse telling program_counter to increment.
REQ-006 SHALL have port pc_write  output  1  one-cycle pulse telling program_counter to load pc_addr.
REQ-007 SHALL have port pc_addr  output  10  redirect target for program_counter.
REQ-008 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-009 SHALL have port imem_addr  output  10  instruction-memory read address.
REQ-010 SHALL have port imem_ack  input  1  memory returns imem_data this cycle.
REQ-011 SHALL have port imem_data  input  32  instruction word.
REQ-012 SHALL have port branch_valid  input  1  redirect request from execute.
REQ-013 SHALL have port branch_target  input  10  redirect address.
REQ-014 SHALL have port instr  output  32  held instruction to decode.
REQ-015 SHALL have port instr_valid  output  1  instr is valid for decode.
REQ-016 SHALL have port instr_ready  input  1  decode accepts instr.
REQ-017 SHALL have port halted  output  1  fetch stopped on PC overflow.

Function
REQ-018 SHALL implement states IDLE, FETCH, HOLD, REDIRECT, HALT; all outputs are registered except imem_addr.
REQ-019 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-020 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc combinationally; imem_req SHALL stay high until imem_ack is received.
REQ-021 FETCH with imem_ack=1 SHALL, on the same edge, capture imem_data into instr, set instr_valid=1, pulse fetch for exactly one cycle and enter HOLD; zero-wait ack (same cycle as req) SHALL be supported.
REQ-022 In HOLD, instr and instr_valid SHALL be stable until instr_valid&&instr_ready; on that edge instr_valid SHALL clear and the state SHALL go to FETCH.
REQ-023 fetch pulse SHALL occur once per accepted instruction; no new request SHALL issue until the next FETCH, so imem_addr always sees the incremented pc.
REQ-024 branch_valid=1 in FETCH, HOLD or HALT SHALL pulse pc_write for one cycle with pc_addr=branch_target (captured on that edge), clear instr_valid, clear halted and enter REDIRECT.
REQ-025 A branch in FETCH SHALL abort the request; an imem_ack in the same cycle SHALL be discarded with no fetch pulse.
REQ-026 A branch in HOLD coincident with instr_valid&&instr_ready SHALL count the transfer as completed, then redirect.
REQ-027 REDIRECT SHALL last one cycle (pc update) then go to FETCH; branch_valid in REDIRECT or IDLE SHALL be ignored.
REQ-028 In FETCH with pc_overflow=1 and no branch, no request SHALL issue; state SHALL go to HALT with halted=1.
REQ-029 HALT SHALL hold imem_req=0, fetch=0, instr_valid=0 until a branch (REQ-024) or reset.
REQ-030 fetch and pc_write SHALL never be high in the same cycle.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force state IDLE, fetch=0, pc_write=0, pc_addr=0, imem_req=0, instr=0, instr_valid=0, halted=0, from any state including mid-request; a pending imem_ack SHALL be ignored.

Verification
REQ-032 Reset then pc=0, ack on 2nd FETCH cycle, data 32'hDEADBEEF, instr_ready=1 -> imem_addr=0, one fetch pulse, instr=DEADBEEF valid one cycle, next request at pc=1.
REQ-033 instr_ready=0 for 5 cycles -> instr_valid and instr stable, imem_req=0 throughout, no extra fetch pulse.
REQ-034 branch_valid with target 10'd50 while in HOLD -> pc_write pulse, pc_addr=50, instr_valid cleared, REDIRECT then FETCH with imem_addr=50.
REQ-035 branch_valid target 10'd100 coincident with imem_ack -> data discarded, fetch=0, pc_write=1, next request at 100.
REQ-036 pc=1023 fetched, pc_overflow=1 in next FETCH -> halted=1, imem_req=0; branch target 10'd5 -> halted=0, fetch resumes at 5.
REQ-037 rst_n=0 mid-FETCH with ack pending -> all outputs reset next edge, IDLE then FETCH after release.
